// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit adder ALU and its sequential multiplier controller.
package alu_pkg;

  localparam int ALU_W     = 16;
  localparam int MUL_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Iteration index on which the final partial product is folded in.
  localparam logic [MUL_CNT_W-1:0] MUL_LAST_CNT = MUL_CNT_W'(ALU_W - 1);

endpackage

// File: rtl/alu_mul_seq_if.sv
// Handshake, product and shared-adder signals of the sequential multiplier.
interface alu_mul_seq_if;
  import alu_pkg::*;

  logic               start;
  logic [ALU_W-1:0]   A;
  logic [ALU_W-1:0]   B;
  logic [ALU_W-1:0]   alu_X;
  logic [ALU_W-1:0]   alu_Y;
  logic [ALU_W-1:0]   alu_Z;
  logic               alu_Carry;
  logic               busy;
  logic               done;
  logic [2*ALU_W-1:0] P;
  logic               P_zero;
  logic               P_ovf;

  // Parent side: issues requests and hosts the shared adder.
  modport master (
    output start, A, B, alu_Z, alu_Carry,
    input  alu_X, alu_Y, busy, done, P, P_zero, P_ovf
  );

  // Multiplier side.
  modport slave (
    input  start, A, B, alu_Z, alu_Carry,
    output alu_X, alu_Y, busy, done, P, P_zero, P_ovf
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add 16x16 unsigned multiplier driving an external adder, one partial product per clock.
// Optional build macro ALU_MUL_EARLY_TERM_EN: zero operand completes straight from IDLE.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mul_seq_if.slave bus
);

  mul_state_t           state_reg, state_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [WIDTH-1:0]     acc_hi_reg, acc_hi_next;
  logic [WIDTH-1:0]     acc_lo_reg, acc_lo_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   p_reg, p_next;
  logic                 p_zero_reg, p_zero_next;
  logic                 p_ovf_reg, p_ovf_next;
  logic [2*WIDTH-1:0]   shifted;

  // 33-bit {carry, sum, acc_lo} shifted right by one; the LSB of acc_lo falls off.
  assign shifted = {bus.alu_Carry, bus.alu_Z, acc_lo_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      cnt_reg    <= '0;
      p_reg      <= '0;
      p_zero_reg <= 1'b1;
      p_ovf_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      acc_hi_reg <= acc_hi_next;
      acc_lo_reg <= acc_lo_next;
      cnt_reg    <= cnt_next;
      p_reg      <= p_next;
      p_zero_reg <= p_zero_next;
      p_ovf_reg  <= p_ovf_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    acc_hi_next = acc_hi_reg;
    acc_lo_next = acc_lo_reg;
    cnt_next    = cnt_reg;
    p_next      = p_reg;
    p_zero_next = p_zero_reg;
    p_ovf_next  = p_ovf_reg;

    case (state_reg)
      IDLE, DONE: begin
        // DONE accepts a new start just like IDLE so operations can run back to back.
        if (bus.start) begin
          a_next      = bus.A;
          acc_lo_next = bus.B;
          acc_hi_next = '0;
          cnt_next    = '0;
`ifdef ALU_MUL_EARLY_TERM_EN
          if ((bus.A == '0) || (bus.B == '0)) begin
            state_next  = DONE;
            p_next      = '0;
            p_zero_next = 1'b1;
            p_ovf_next  = 1'b0;
          end else begin
            state_next = RUN;
          end
`else
          state_next = RUN;
`endif
        end else begin
          state_next = IDLE;
        end
      end

      RUN: begin
        acc_hi_next = shifted[2*WIDTH-1:WIDTH];
        acc_lo_next = shifted[WIDTH-1:0];
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == MUL_LAST_CNT) begin
          state_next  = DONE;
          p_next      = shifted;
          p_zero_next = (shifted == '0);
          p_ovf_next  = (shifted[2*WIDTH-1:WIDTH] != '0);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = (state_reg == DONE);
  assign bus.alu_X  = acc_hi_reg;
  assign bus.alu_Y  = ((state_reg == RUN) && acc_lo_reg[0]) ? a_reg : '0;
  assign bus.P      = p_reg;
  assign bus.P_zero = p_zero_reg;
  assign bus.P_ovf  = p_ovf_reg;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: product model plus directed literal checks.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mul_seq_if bus();

  // The shared adder lives in the parent; here it is a plain combinational sum.
  logic [16:0] sum;
  assign sum           = {1'b0, bus.alu_X} + {1'b0, bus.alu_Y};
  assign bus.alu_Z     = sum[15:0];
  assign bus.alu_Carry = sum[16];

  alu_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: phase 0 idle, 1 running (m_left cycles to go), 2 done; product via plain multiply.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_p     = '0;
  logic [31:0] m_pend  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_p     <= '0;
    end else if (m_phase == 1) begin
      if (m_left == 1) begin
        m_phase <= 2;
        m_p     <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (bus.start === 1'b1) begin
      m_pend <= 32'(bus.A) * 32'(bus.B);
`ifdef ALU_MUL_EARLY_TERM_EN
      if (bus.A == 16'd0 || bus.B == 16'd0) begin
        m_phase <= 2;
        m_p     <= '0;
      end else begin
        m_phase <= 1;
        m_left  <= 16;
      end
`else
      m_phase <= 1;
      m_left  <= 16;
`endif
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    chk("model busy",   32'(bus.busy),   32'(m_phase == 1));
    chk("model done",   32'(bus.done),   32'(m_phase == 2));
    chk("model P",      bus.P,           m_p);
    chk("model P_zero", 32'(bus.P_zero), 32'(m_p == 32'd0));
    chk("model P_ovf",  32'(bus.P_ovf),  32'(m_p[31:16] != 16'd0));
    if (m_phase != 1) chk("model alu_Y idle", 32'(bus.alu_Y), 32'd0);
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"},   32'(bus.busy),   32'd0);
    chk({tag, " done"},   32'(bus.done),   32'd0);
    chk({tag, " P"},      bus.P,           32'd0);
    chk({tag, " P_zero"}, 32'(bus.P_zero), 32'd1);
    chk({tag, " P_ovf"},  32'(bus.P_ovf),  32'd0);
    chk({tag, " alu_X"},  32'(bus.alu_X),  32'd0);
    chk({tag, " alu_Y"},  32'(bus.alu_Y),  32'd0);
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    #1;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
  endtask

  // n counts clock edges after the accepting edge when done is first seen.
  task automatic wait_done(input string name, input logic [31:0] exp_p, input int exp_lat,
                           input logic exp_zero, input logic exp_ovf, input int pulse_at);
    int   n = -1;
    logic d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      d = bus.done;
      if (i == 0) begin
        #1;
        bus.start = 1'b0;
        bus.A     = 16'hDEAD;
        bus.B     = 16'hBEEF;
      end
      if (pulse_at > 0 && i == pulse_at) begin
        #1;
        bus.start = 1'b1;
        bus.A     = 16'hFFFF;
        bus.B     = 16'hFFFF;
      end
      if (pulse_at > 0 && i == pulse_at + 1) begin
        #1;
        bus.start = 1'b0;
      end
      if (d) begin
        n = i;
        break;
      end
    end
    chk({name, " latency"}, 32'(n), 32'(exp_lat));
    chk({name, " P"},       bus.P,  exp_p);
    chk({name, " P_zero"},  32'(bus.P_zero), 32'(exp_zero));
    chk({name, " P_ovf"},   32'(bus.P_ovf),  32'(exp_ovf));
    $display("op %s: P=0x%08h latency=%0d", name, bus.P, n);
  endtask

  localparam int ZERO_LAT =
`ifdef ALU_MUL_EARLY_TERM_EN
    0;
`else
    16;
`endif

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post-release");

    @(negedge clk);
    launch(16'd3, 16'd5);
    wait_done("3x5", 32'h0000_000F, 16, 1'b0, 1'b0, 0);

    @(negedge clk);
    launch(16'hFFFF, 16'hFFFF);
    wait_done("FFFFxFFFF", 32'hFFFE_0001, 16, 1'b0, 1'b1, 0);

    @(negedge clk);
    launch(16'h1234, 16'h0000);
    wait_done("1234x0", 32'h0000_0000, ZERO_LAT, 1'b1, 1'b0, 0);
    launch(16'h0100, 16'h0100);
    wait_done("b2b 100x100", 32'h0001_0000, 16, 1'b0, 1'b1, 0);

    @(negedge clk);
    launch(16'h00AB, 16'h0CD0);
    wait_done("start-while-busy", 32'h0008_8EF0, 16, 1'b0, 1'b1, 5);
    repeat (2) @(negedge clk);
    chk("single done pulse", 32'(bus.done), 32'd0);

    @(negedge clk);
    launch(16'h1111, 16'h2222);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        #1 bus.start = 1'b0;
      end
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid-run reset");
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no done after reset", 32'(bus.done), 32'd0);

    @(negedge clk);
    launch(16'd7, 16'd9);
    wait_done("7x9", 32'h0000_003F, 16, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
